vmmul_wb_sink: RTL and testbench



---
 rtl/vmmul_pkg.sv | 18 +
 rtl/vmmul_wb_fifo.sv | 59 +++++
 rtl/vmmul_wb_sink.sv | 163 ++++++++++++++++
 tb/tb_vmmul_wb_sink.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmmul_pkg.sv
// Shared definitions for the VMMUL result path: word geometry and write-engine states.
package vmmul_pkg;

  localparam int WORD_W          = 32;
  localparam int MAT_DIM         = 4;
  localparam int FRAME_WORDS_DEF = MAT_DIM * MAT_DIM;
  localparam int ADDR_STRIDE     = 4;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_REQ
  } wb_state_e;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/vmmul_wb_fifo.sv
// Small synchronous FIFO of {addr,data}; exposes the head and the entry behind it
// so the write engine can chain requests without a bubble.
module vmmul_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign next_data = mem[rd_ptr_reg + AW'(1)];
  assign count     = count_reg;
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/vmmul_wb_sink.sv
// VMMUL result sink: buffers STORE-phase words and retires them over a req/ack write port.
// Optional VMMUL_WB_CHECKSUM_EN adds a per-frame sum of written data on frame_checksum.
module vmmul_wb_sink
  import vmmul_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic [WORD_W-1:0] in_addr,
  input  logic              clear,
  output logic              mem_wr_req,
  output logic [WORD_W-1:0] mem_wr_addr,
  output logic [WORD_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              busy,
  output logic              wb_done,
  output logic [4:0]        words_written,
  output logic              overflow,
  output logic              align_err
`ifdef VMMUL_WB_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] frame_checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] LAST_WORD = 5'(FRAME_WORDS - 1);

  wb_state_e             state_reg;
  logic                  req_reg;
  logic [WORD_W-1:0]     addr_reg;
  logic [WORD_W-1:0]     data_reg;
  logic [4:0]            words_reg;
  logic                  done_reg;
  logic                  overflow_reg;
  logic                  align_err_reg;

  logic [2*WORD_W-1:0]   fifo_head;
  logic [2*WORD_W-1:0]   fifo_next;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  aligned;
  logic                  pop;
  logic                  push_ok;
  logic                  align_hit;
  logic                  ovf_hit;

  assign aligned   = is_word_aligned(in_addr);
  assign pop       = (state_reg == WB_REQ) && mem_wr_ack;
  // A full FIFO still takes the word when the head retires on the same edge.
  assign push_ok   = in_valid && aligned && (!fifo_full || pop);
  assign align_hit = in_valid && !aligned;
  assign ovf_hit   = in_valid && aligned && fifo_full && !pop;

  vmmul_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data ({in_addr, in_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .next_data (fifo_next),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The word under request is always the FIFO head; it pops only on its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WB_IDLE;
      req_reg       <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      words_reg     <= '0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      overflow_reg  <= (overflow_reg & ~clear) | ovf_hit;
      align_err_reg <= (align_err_reg & ~clear) | align_hit;
      case (state_reg)
        WB_IDLE: begin
          if (!fifo_empty) begin
            {addr_reg, data_reg} <= fifo_head;
            req_reg   <= 1'b1;
            state_reg <= WB_REQ;
          end else if (push_ok) begin
            addr_reg  <= in_addr;
            data_reg  <= in_data;
            req_reg   <= 1'b1;
            state_reg <= WB_REQ;
          end
        end
        WB_REQ: begin
          if (mem_wr_ack) begin
            if (words_reg == LAST_WORD) begin
              words_reg <= '0;
              done_reg  <= 1'b1;
            end else begin
              words_reg <= words_reg + 5'd1;
            end
            // Chain straight into the next word, forwarding the input if it lands now.
            if (fifo_count > CNT_W'(1)) begin
              {addr_reg, data_reg} <= fifo_next;
            end else if (push_ok) begin
              addr_reg <= in_addr;
              data_reg <= in_data;
            end else begin
              req_reg   <= 1'b0;
              state_reg <= WB_IDLE;
            end
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= WB_IDLE;
        end
      endcase
    end
  end

`ifdef VMMUL_WB_CHECKSUM_EN
  logic [WORD_W-1:0] sum_reg;
  logic [WORD_W-1:0] checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg      <= '0;
      checksum_reg <= '0;
    end else if (pop) begin
      if (words_reg == LAST_WORD) begin
        checksum_reg <= sum_reg + data_reg;
        sum_reg      <= '0;
      end else begin
        sum_reg <= sum_reg + data_reg;
      end
    end
  end

  assign frame_checksum = checksum_reg;
`endif

  assign mem_wr_req    = req_reg;
  assign mem_wr_addr   = addr_reg;
  assign mem_wr_data   = data_reg;
  assign busy          = req_reg | ~fifo_empty;
  assign wb_done       = done_reg;
  assign words_written = words_reg;
  assign overflow      = overflow_reg;
  assign align_err     = align_err_reg;

endmodule

// File: tb/tb_vmmul_wb_sink.sv
// Scoreboard bench for vmmul_wb_sink: stimulus queues expected writes, a negedge monitor retires them.
module tb_vmmul_wb_sink;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic        clear;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        busy;
  logic        wb_done;
  logic [4:0]  words_written;
  logic        overflow;
  logic        align_err;
`ifdef VMMUL_WB_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  vmmul_wb_sink #(
    .FIFO_DEPTH  (4),
    .FRAME_WORDS (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_addr       (in_addr),
    .clear         (clear),
    .mem_wr_req    (mem_wr_req),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ack    (mem_wr_ack),
    .busy          (busy),
    .wb_done       (wb_done),
    .words_written (words_written),
    .overflow      (overflow),
    .align_err     (align_err)
`ifdef VMMUL_WB_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          dones  = 0;
  logic [31:0] c_mat [16];
  logic [31:0] frame_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle; a write retires at the next edge when req and ack are both high.
  logic        prev_req   = 1'b0;
  logic        prev_acked = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst_n) begin
      prev_req   = 1'b0;
      prev_acked = 1'b0;
    end else begin
      if (prev_req && !prev_acked && mem_wr_req) begin
        check("hold_addr", mem_wr_addr, prev_addr);
        check("hold_data", mem_wr_data, prev_data);
      end
      if (mem_wr_req && mem_wr_ack) begin
        writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                   mem_wr_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          $display("write %0d: addr 0x%08h data 0x%08h (exp 0x%08h 0x%08h)",
                   writes, mem_wr_addr, mem_wr_data, e.addr, e.data);
          check("wr_addr", mem_wr_addr, e.addr);
          check("wr_data", mem_wr_data, e.data);
        end
      end
      if (wb_done) dones++;
      prev_req   = mem_wr_req;
      prev_acked = mem_wr_req && mem_wr_ack;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic ack);
    in_valid   = v;
    in_addr    = a;
    in_data    = d;
    mem_wr_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, ack);
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    mem_wr_ack = 1'b0;
    clear      = 1'b0;
    rst_n      = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int          w0;
  int          d0;
  logic [31:0] addr_v;
  logic [31:0] sum4;

  initial begin
    // C = A*B with A = 1..16, B = 5..20 (row-major); C[0] = 130.
    frame_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c_mat[i*4+j] = '0;
        for (int k = 0; k < 4; k++) begin
          c_mat[i*4+j] += 32'((i*4 + k + 1) * (k*4 + j + 5));
        end
        frame_sum += c_mat[i*4+j];
      end
    end

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; clear = 1'b0; mem_wr_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, mem_wr_req}, 32'd0);
    check("rst_addr", mem_wr_addr, 32'd0);
    check("rst_data", mem_wr_data, 32'd0);
    check("rst_flags", {26'b0, busy, wb_done, overflow, align_err, 2'b0}, 32'd0);
    check("rst_words", {27'b0, words_written}, 32'd0);
    rst_n = 1'b1;

    // Full frame with ack held high.
    w0 = writes; d0 = dones;
    for (int i = 0; i < 16; i++) begin
      addr_v = 32'h1000 + 32'(4*i);
      expect_wr(addr_v, c_mat[i]);
      step(1'b1, addr_v, c_mat[i], 1'b1);
      if (i == 0) begin
        check("t1_first_req", {31'b0, mem_wr_req}, 32'd1);
        check("t1_first_addr", mem_wr_addr, 32'h1000);
        check("t1_first_data", mem_wr_data, 32'd130);
      end
    end
    idle(6, 1'b1);
    check("t1_writes", 32'(writes - w0), 32'd16);
    check("t1_done", 32'(dones - d0), 32'd1);
    check("t1_words", {27'b0, words_written}, 32'd0);
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    check("t1_busy", {31'b0, busy}, 32'd0);
`ifdef VMMUL_WB_CHECKSUM_EN
    check("t1_checksum", frame_checksum, frame_sum);
`endif

    // Ack stalled for 20 cycles: only the first 4 words fit.
    do_reset();
    w0 = writes; d0 = dones;
    for (int i = 0; i < 16; i++) begin
      addr_v = 32'h3000 + 32'(4*i);
      if (i < 4) expect_wr(addr_v, c_mat[i]);
      step(1'b1, addr_v, c_mat[i], 1'b0);
    end
    idle(4, 1'b0);
    check("t2_overflow", {31'b0, overflow}, 32'd1);
    check("t2_stalled_writes", 32'(writes - w0), 32'd0);
    idle(8, 1'b1);
    check("t2_writes", 32'(writes - w0), 32'd4);
    check("t2_done", 32'(dones - d0), 32'd0);
    check("t2_words", {27'b0, words_written}, 32'd4);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    clear = 1'b1;
    idle(1, 1'b1);
    clear = 1'b0;
    check("t2_clear_overflow", {31'b0, overflow}, 32'd0);
    check("t2_clear_words", {27'b0, words_written}, 32'd4);

    // Ack on alternate edges: word 8 lands on a full FIFO with a pop, word 9 on full without.
    do_reset();
    w0 = writes;
    for (int t = 1; t <= 9; t++) begin
      addr_v = 32'h2000 + 32'(4*t);
      if (t <= 8) expect_wr(addr_v, c_mat[t-1]);
      step(1'b1, addr_v, c_mat[t-1], (t % 2) == 0);
    end
    check("t3_overflow", {31'b0, overflow}, 32'd1);
    idle(8, 1'b1);
    check("t3_writes", 32'(writes - w0), 32'd8);
    check("t3_queue", 32'(exp_q.size()), 32'd0);
    check("t3_align", {31'b0, align_err}, 32'd0);

    // Misaligned word 3 is dropped; a 17th input completes the frame.
    do_reset();
    w0 = writes; d0 = dones;
    sum4 = '0;
    for (int i = 0; i < 16; i++) begin
      addr_v = (i == 2) ? 32'h1002 : 32'h1000 + 32'(4*i);
      if (i != 2) begin
        expect_wr(addr_v, c_mat[i]);
        sum4 += c_mat[i];
      end
      step(1'b1, addr_v, c_mat[i], 1'b1);
    end
    idle(4, 1'b1);
    check("t4_align", {31'b0, align_err}, 32'd1);
    check("t4_overflow", {31'b0, overflow}, 32'd0);
    check("t4_writes", 32'(writes - w0), 32'd15);
    check("t4_no_done", 32'(dones - d0), 32'd0);
    check("t4_words", {27'b0, words_written}, 32'd15);
    expect_wr(32'h1040, 32'hDEAD_BEEF);
    sum4 += 32'hDEAD_BEEF;
    step(1'b1, 32'h1040, 32'hDEAD_BEEF, 1'b1);
    idle(4, 1'b1);
    check("t4_done", 32'(dones - d0), 32'd1);
    check("t4_words_wrap", {27'b0, words_written}, 32'd0);
    check("t4_queue", 32'(exp_q.size()), 32'd0);
`ifdef VMMUL_WB_CHECKSUM_EN
    check("t4_checksum", frame_checksum, sum4);
`endif

    // Reset asserted mid-handshake.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h4000 + 32'(4*i), c_mat[i], 1'b0);
    end
    in_valid = 1'b0;
    check("t5_req_before", {31'b0, mem_wr_req}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_req", {31'b0, mem_wr_req}, 32'd0);
    check("t5_rst_addr", mem_wr_addr, 32'd0);
    check("t5_rst_data", mem_wr_data, 32'd0);
    check("t5_rst_flags", {28'b0, busy, wb_done, overflow, align_err}, 32'd0);
    check("t5_rst_words", {27'b0, words_written}, 32'd0);
    exp_q.delete();
    mem_wr_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = writes; d0 = dones;
    for (int i = 0; i < 16; i++) begin
      addr_v = 32'h5000 + 32'(4*i);
      expect_wr(addr_v, c_mat[i]);
      step(1'b1, addr_v, c_mat[i], 1'b1);
    end
    idle(6, 1'b1);
    check("t5_writes", 32'(writes - w0), 32'd16);
    check("t5_done", 32'(dones - d0), 32'd1);
    check("t5_words", {27'b0, words_written}, 32'd0);
    check("t5_queue", 32'(exp_q.size()), 32'd0);
`ifdef VMMUL_WB_CHECKSUM_EN
    check("t5_checksum", frame_checksum, frame_sum);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
